// File: rtl/egg_timer_ctrl.sv
// Egg timer control FSM: synchronizes and debounces the two active-low keys,
// then steps the set/ready/timer/flash sequence on the accepted presses.
module egg_timer_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] KEY,
    input  logic       timeout,
    output logic [3:0] state,
    output logic [1:0] key_press
);

    typedef enum logic [3:0] {
        ST_SET_SEC     = 4'h0,
        ST_SET_MIN     = 4'h1,
        ST_TIMER       = 4'h2,
        ST_READY       = 4'h3,
        ST_RESET       = 4'h4,
        ST_FLASH       = 4'h5,
        ST_SEC_MIN     = 4'h7,
        ST_READY_TIMER = 4'h9,
        ST_MIN_READY   = 4'hA,
        ST_TIMER_READY = 4'hB
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           cur_state;
    logic [1:0]       sync_1;
    logic [1:0]       sync_2;
    logic [1:0]       deb_level;
    logic [1:0]       deb_prev;
    logic [CNT_W-1:0] deb_cnt [2];

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_1     <= 2'b11;
            sync_2     <= 2'b11;
            deb_level  <= 2'b11;
            deb_prev   <= 2'b11;
            key_press  <= 2'b00;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync_1    <= KEY;
            sync_2    <= sync_1;
            deb_prev  <= deb_level;
            key_press <= deb_prev & ~deb_level;
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] != deb_level[i]) begin
                    if (deb_cnt[i] == CNT_LAST) begin
                        deb_level[i] <= sync_2[i];
                        deb_cnt[i]   <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Transient states last one cycle so the top level can latch values or swap the display.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cur_state <= ST_RESET;
        end else begin
            case (cur_state)
                ST_RESET:       cur_state <= ST_SET_SEC;
                ST_SET_SEC:     if (key_press[0]) cur_state <= ST_SEC_MIN;
                ST_SEC_MIN:     cur_state <= ST_SET_MIN;
                ST_SET_MIN:     if (key_press[0]) cur_state <= ST_MIN_READY;
                ST_MIN_READY:   cur_state <= ST_READY;
                ST_READY:       if (key_press[1]) cur_state <= ST_READY_TIMER;
                ST_READY_TIMER: cur_state <= ST_TIMER;
                ST_TIMER: begin
                    if (timeout)
                        cur_state <= ST_FLASH;
                    else if (key_press[1])
                        cur_state <= ST_TIMER_READY;
                end
                ST_TIMER_READY: cur_state <= ST_READY;
                ST_FLASH:       if (|key_press) cur_state <= ST_RESET;
                default:        cur_state <= ST_RESET;
            endcase
        end
    end

    assign state = cur_state;

endmodule
